// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle for rr_mux_arbiter.
// Request side:  valid_i/data_i in, ready_o out (one bit per channel,
//                channel k's word at data_i[k*Size +: Size]).
// Result side:   valid_o/data_o/sel_o out, ready_i in.
// master: the producer/consumer environment. slave: the arbiter itself.
interface rr_mux_arbiter_if #(
  parameter int Size   = 64,
  parameter int Inputs = 4
);
  localparam int SelW = $clog2(Inputs);

  logic [Inputs-1:0]      valid_i;
  logic [Inputs*Size-1:0] data_i;
  logic [Inputs-1:0]      ready_o;
  logic                   valid_o;
  logic [Size-1:0]        data_o;
  logic [SelW-1:0]        sel_o;
  logic                   ready_i;

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, sel_o
  );

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, sel_o
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Registered N-to-1 multiplexer with round-robin arbitration.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high
//   bus    - rr_mux_arbiter_if.slave: per-channel valid_i/data_i/ready_o
//            requests, registered valid_o/data_o/sel_o result with ready_i.
// One valid channel is granted per cycle whenever the output register can
// load; priority starts just after the most recently granted channel.
module rr_mux_arbiter #(
  parameter int Size   = 64,
  parameter int Inputs = 4
) (
  input logic            clk,
  input logic            reset,
  rr_mux_arbiter_if.slave bus
);
  localparam int SelW = $clog2(Inputs);
  localparam int SumW = SelW + 1;
  localparam logic [SumW-1:0] InputsW  = SumW'(Inputs);
  localparam logic [SelW-1:0] LastInit = SelW'(Inputs - 1);

  // Unpacked view of the packed input words.
  logic [Size-1:0] word [Inputs];

  genvar gi;
  generate
    for (gi = 0; gi < Inputs; gi++) begin : g_unpack
      assign word[gi] = bus.data_i[gi*Size +: Size];
    end
  endgenerate

  logic            valid_q, valid_d;
  logic [Size-1:0] data_q, data_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] last_q, last_d;

  logic              load_en;
  logic              found;
  logic              transfer;
  logic [SelW-1:0]   grant_idx;
  logic [Inputs-1:0] grant;
  logic [SumW-1:0]   cand_sum;
  logic [SelW-1:0]   cand;

  // Scan channels last+1, last+2, ... wrapping modulo Inputs; first valid
  // one wins. The extra sum bit lets the wrap work for non-power-of-two
  // channel counts.
  always_comb begin : arbitrate
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int off = 1; off <= Inputs; off++) begin
      cand_sum = {1'b0, last_q} + SumW'(off);
      if (cand_sum >= InputsW) begin
        cand_sum = cand_sum - InputsW;
      end
      cand = cand_sum[SelW-1:0];
      if (!found && bus.valid_i[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign load_en     = !valid_q || bus.ready_i;
  // ready_o never depends on data_i; it is forced low during reset.
  assign bus.ready_o = (load_en && !reset) ? grant : '0;
  assign transfer    = found && load_en && !reset;

  always_comb begin : next_state
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (transfer) begin
      valid_d = 1'b1;
      data_d  = word[grant_idx];
      sel_d   = grant_idx;
      last_d  = grant_idx;
    end else if (valid_q && bus.ready_i) begin
      // Drain without refill: word and index stay visible, only valid drops.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= LastInit;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.sel_o   = sel_q;
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Parametrised, registered N-to-1 multiplexer with round-robin arbitration and valid/ready handshakes on every input channel and on the output. It generalises the datapath 2-to-1 mux into a shared-resource selector, for example several requesters competing for a single writeback or memory port. The selection is no longer driven by an external `sel`: the block grants one valid channel per cycle with fair rotation and holds the winning word in an output register until the consumer accepts it.

## Interface
Parameters:
- `Size`, 64, width in bits of each data word.
- `Inputs`, 4, number of input channels; legal range is 2 or more.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `valid_i`  input  `Inputs`  bit k high means channel k presents a word.
- `data_i`  input  `Inputs*Size`  packed words; channel k occupies bits [k*Size +: Size].
- `ready_o`  output  `Inputs`  bit k high means channel k's word is accepted this cycle.
- `valid_o`  output  1  the output register holds a word.
- `data_o`  output  `Size`  the registered winning word.
- `sel_o`  output  `$clog2(Inputs)`  index of the channel that supplied `data_o`.
- `ready_i`  input  1  the consumer accepts `data_o` this cycle.

## Operation
- The output register can load when `load_en = !valid_o || ready_i`.
- Arbitration:
  - Priority order starts at channel `(last + 1) mod Inputs` and wraps upward.
  - `last` is the most recently granted channel.
  - `grant` is one-hot: the first channel in that order whose `valid_i` bit is high. It is all-zero when no channel is valid.
- `ready_o = grant` when `load_en` is high, otherwise all-zero. At most one bit is high at any time.
- Transfer on channel k happens when `valid_i[k] && ready_o[k]`. On that clock edge:
  - `data_o` loads `data_i[k]`.
  - `sel_o` loads k.
  - `valid_o` is set.
  - `last` loads k.
- Output drain: when `valid_o && ready_i` and there is no new transfer in the same cycle, `valid_o` clears. `data_o` and `sel_o` keep their values.
- Simultaneous drain and load: when `valid_o && ready_i` and a new transfer happen in the same cycle, the register reloads and `valid_o` stays high. This gives a throughput of one word per cycle.
- Stall: while `valid_o && !ready_i`, the following are frozen:
  - `data_o`, `sel_o`, `valid_o`
  - `last`
  - every `ready_o` bit, held low
- `last` changes only when a transfer happens. Idle cycles do not rotate the priority.
- Producer rule: a channel holds `valid_i` high and `data_i` stable until it is accepted. The block does not check for violations.
- Reset values:
  - `valid_o` = 0, `data_o` = 0, `sel_o` = 0.
  - `last` = `Inputs-1`, so channel 0 has top priority on the first arbitration.
  - `ready_o` = 0 while `reset` is high.
- Reset during operation discards any word held in the output register. Arbitration resumes from channel 0 on the first cycle after `reset` is released.

## Timing
- `ready_o` is combinational from `valid_i`, `valid_o`, `ready_i` and `last`. No path runs from `data_i` to `ready_o`.
- `valid_o`, `data_o` and `sel_o` are pure register outputs.
- Latency: a word accepted at edge t is visible on `data_o` from edge t onward, i.e. during cycle t+1.
- Fairness: with all channels continuously valid and `ready_i` high, grants cycle 0, 1, …, `Inputs-1`, 0, … with one grant per cycle. Each channel waits at most `Inputs-1` transfers.
- A single valid channel with `ready_i` high transfers every cycle. Rotation always lands back on it.

## Test plan
- Reset with `Inputs=4`, `Size=64`, all `valid_i=4'b1111`, `ready_i=1` → during reset `ready_o=0` and `valid_o=0`. After release, `sel_o` sequence is 0,1,2,3,0 on consecutive cycles and `data_o` matches each channel's word, e.g. channel 2 = `64'hDEADBEEF_00000002`.
- Only channel 3 valid with `data_i` = `64'hA5A5…` and `ready_i=1` → `ready_o=4'b1000` every cycle, `sel_o=3`, and `valid_o` stays high for 5 consecutive cycles.
- Backpressure: load channel 1, then set `ready_i=0` for 3 cycles with channels 0 and 2 valid → `data_o` and `sel_o=1` are stable and `ready_o=0`. When `ready_i` returns to 1, channel 2 is granted before channel 0.
- Drain with no new request: `valid_o=1`, `ready_i=1`, `valid_i=0` → `valid_o=0` on the next cycle and `data_o` keeps its last value.
- Reset mid-stall: `valid_o=1`, `ready_i=0`, assert `reset` for 1 cycle → `valid_o=0`, `data_o=0`, `sel_o=0`. The next grant with all channels valid goes to channel 0.
- Random: `{$urandom,$urandom}` words on random `valid_i`/`ready_i` patterns for 1000 cycles → each output word equals a scoreboard model and no channel starves for more than `Inputs-1` transfers. The bench reports `Finished, got  0 errors`.
